// File: rtl/flag_handshake_tx_if.sv
// rtl/flag_handshake_tx_if.sv - event-flag toggle handshake bundle between the event source and the transmitter
interface flag_handshake_tx_if #(
    parameter int CNT_W = 4
);
    logic             flag_in;
    logic             ack_toggle;
    logic             overflow_clr;
    logic             req_toggle;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pending;
    logic             overflow;
    logic             proto_err;

    // Event source / remote-ack side: drives events, ack level and overflow clear.
    modport master (
        output flag_in,
        output ack_toggle,
        output overflow_clr,
        input  req_toggle,
        input  busy,
        input  done,
        input  pending,
        input  overflow,
        input  proto_err
    );

    // Transmitter side.
    modport slave (
        input  flag_in,
        input  ack_toggle,
        input  overflow_clr,
        output req_toggle,
        output busy,
        output done,
        output pending,
        output overflow,
        output proto_err
    );
endinterface

// File: rtl/flag_handshake_tx.sv
// rtl/flag_handshake_tx.sv - clk-domain event flags sent to a remote domain as a toggle req/ack handshake with pending counter
module flag_handshake_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    flag_handshake_tx_if.slave hs
);
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } stateT;

    localparam logic [CNT_W-1:0] PENDING_MAX = '1;
    localparam logic [CNT_W-1:0] PENDING_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] ackSync;
    logic                   ackS;

    stateT            state;
    stateT            stateNext;
    logic             reqToggleQ;
    logic             reqToggleNext;
    logic             busyQ;
    logic             doneQ;
    logic             doneNext;
    logic [CNT_W-1:0] pendingQ;
    logic [CNT_W-1:0] pendingNext;
    logic             overflowQ;
    logic             overflowNext;
    logic             protoErrQ;
    logic             protoErrNext;

    logic             launch;
    logic             takePending;
    logic             flagKept;
    logic             dropEvent;

    // ack_toggle is asynchronous: only this chain may look at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ackSync <= '0;
        end else begin
            ackSync <= {ackSync[SYNC_STAGES-2:0], hs.ack_toggle};
        end
    end

    assign ackS = ackSync[SYNC_STAGES-1];

    // State and every output are flops, so nothing combinational reaches the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            reqToggleQ <= 1'b0;
            busyQ      <= 1'b0;
            doneQ      <= 1'b0;
            pendingQ   <= '0;
            overflowQ  <= 1'b0;
            protoErrQ  <= 1'b0;
        end else begin
            state      <= stateNext;
            reqToggleQ <= reqToggleNext;
            busyQ      <= (stateNext == WAIT_ACK);
            doneQ      <= doneNext;
            pendingQ   <= pendingNext;
            overflowQ  <= overflowNext;
            protoErrQ  <= protoErrNext;
        end
    end

    // Launch from IDLE, retire on matching ack, and keep the pending/overflow/error bookkeeping.
    always_comb begin
        stateNext     = state;
        reqToggleNext = reqToggleQ;
        doneNext      = 1'b0;
        launch        = 1'b0;
        takePending   = 1'b0;
        protoErrNext  = protoErrQ;

        case (state)
            IDLE: begin
                // Ack level should already equal req here; a difference is a stray remote toggle.
                if (ackS != reqToggleQ) begin
                    protoErrNext = 1'b1;
                end
                if (hs.flag_in || (pendingQ != '0)) begin
                    launch        = 1'b1;
                    // Backlog goes first; events are indistinguishable so order is irrelevant.
                    takePending   = (pendingQ != '0);
                    reqToggleNext = ~reqToggleQ;
                    stateNext     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // No relaunch on this edge: the next launch is decided from IDLE.
                if (ackS == reqToggleQ) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // A flag that was not sent directly must be queued.
        flagKept  = hs.flag_in && !(launch && !takePending);
        dropEvent = 1'b0;
        pendingNext = pendingQ;
        if (flagKept && !takePending) begin
            if (pendingQ == PENDING_MAX) begin
                dropEvent = 1'b1;
            end else begin
                pendingNext = pendingQ + PENDING_ONE;
            end
        end else if (takePending && !flagKept) begin
            pendingNext = pendingQ - PENDING_ONE;
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (dropEvent) begin
            overflowNext = 1'b1;
        end else if (hs.overflow_clr) begin
            overflowNext = 1'b0;
        end else begin
            overflowNext = overflowQ;
        end
    end

    assign hs.req_toggle = reqToggleQ;
    assign hs.busy       = busyQ;
    assign hs.done       = doneQ;
    assign hs.pending    = pendingQ;
    assign hs.overflow   = overflowQ;
    assign hs.proto_err  = protoErrQ;
endmodule

// File: tb/tb_flag_handshake_tx.sv
// tb/tb_flag_handshake_tx.sv - randomized scoreboard bench for flag_handshake_tx against an event-level model
module tb_flag_handshake_tx;
    localparam int SYNC = 3;
    localparam int CW   = 2;
    localparam int MAXP = (1 << CW) - 1;
    localparam int RW   = CW + 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    flag_handshake_tx_if #(.CNT_W(CW)) hs ();

    flag_handshake_tx #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hs    (hs)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    int cycleNo = 0;

    logic [RW-1:0] expQ[$];

    // Reference: request outstanding or not, event backlog count, sticky flags, delayed ack view.
    bit mOut;
    bit mReq;
    int mPend;
    bit mOvf;
    bit mPerr;
    bit ackLine[$];

    // Remote responder model.
    bit ackLvl;
    int respCnt;
    int respMax;
    bit spurEn;

    function automatic logic [RW-1:0] snapshot();
        return {hs.req_toggle, hs.busy, hs.done, hs.pending, hs.overflow, hs.proto_err};
    endfunction

    task automatic modelReset();
        mOut  = 1'b0;
        mReq  = 1'b0;
        mPend = 0;
        mOvf  = 1'b0;
        mPerr = 1'b0;
        ackLine.delete();
        for (int i = 0; i < SYNC; i++) ackLine.push_back(1'b0);
        ackLvl  = 1'b0;
        respCnt = 0;
    endtask

    task automatic checkZero(input string name);
        logic [RW-1:0] got;
        got = snapshot();
        vectors++;
        if (got !== '0) begin
            fails++;
            $display("FAIL %s: got %b want %b (req,busy,done,pending,overflow,proto_err)", name, got, {RW{1'b0}});
        end
    endtask

    // Drive one cycle of inputs (at negedge) and queue what the outputs must be after the next posedge.
    task automatic step(input bit flagV, input bit clrV);
        bit ackS;
        bit tookPend;
        bit flagUsed;
        bit doneV;
        int newPend;

        if (ackLvl != mReq) begin
            if (respCnt == 0) ackLvl = mReq;
            else respCnt--;
        end
        if (spurEn && !mOut && ($urandom_range(0, 15) == 0)) ackLvl = ~ackLvl;

        hs.flag_in      = flagV;
        hs.ack_toggle   = ackLvl;
        hs.overflow_clr = clrV;

        ackS = ackLine.pop_front();
        ackLine.push_back(ackLvl);

        tookPend = 1'b0;
        flagUsed = 1'b0;
        doneV    = 1'b0;
        if (!mOut) begin
            if (ackS != mReq) mPerr = 1'b1;
            if (flagV || mPend > 0) begin
                mReq = ~mReq;
                mOut = 1'b1;
                if (mPend > 0) tookPend = 1'b1;
                else flagUsed = 1'b1;
                respCnt = $urandom_range(0, respMax);
            end
        end else if (ackS == mReq) begin
            mOut  = 1'b0;
            doneV = 1'b1;
        end

        newPend = mPend - int'(tookPend) + int'(flagV && !flagUsed);
        if (newPend > MAXP) begin
            newPend = MAXP;
            mOvf    = 1'b1;
        end else if (clrV) begin
            mOvf = 1'b0;
        end
        mPend = newPend;

        expQ.push_back({mReq, mOut, doneV, CW'(mPend), mOvf, mPerr});
    endtask

    task automatic runPhase(input int cycles, input int flagDen, input int clrDen);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            step($urandom_range(0, flagDen - 1) == 0,
                 (clrDen > 0) && ($urandom_range(0, clrDen - 1) == 0));
        end
    endtask

    task automatic doReset(input string name);
        @(negedge clk);
        hs.flag_in      = 1'b0;
        hs.ack_toggle   = 1'b0;
        hs.overflow_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        checkZero(name);
        repeat (2) @(negedge clk);
        checkZero({name, "_held"});
        rst_n = 1'b1;
        modelReset();
    endtask

    // Monitor: every cycle the transmitter presents a registered output set; compare it with the queued one.
    initial begin
        logic [RW-1:0] got;
        logic [RW-1:0] want;
        forever begin
            @(posedge clk);
            #1;
            cycleNo++;
            if (expQ.size() > 0) begin
                want = expQ.pop_front();
                got  = snapshot();
                vectors++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL cycle%0d: got %b want %b (req,busy,done,pending,overflow,proto_err)",
                             cycleNo, got, want);
                end
            end
        end
    end

    initial begin
        hs.flag_in      = 1'b0;
        hs.ack_toggle   = 1'b0;
        hs.overflow_clr = 1'b0;
        spurEn  = 1'b0;
        respMax = 3;
        modelReset();
        repeat (3) @(negedge clk);
        checkZero("reset_state");
        rst_n = 1'b1;

        // Sparse events, quick acknowledges.
        respMax = 3;
        runPhase(300, 8, 0);

        // Dense events with slow acknowledges: backlog, saturation, overflow and its clear.
        respMax = 20;
        runPhase(400, 2, 16);

        // Push to a saturated backlog with a request outstanding, then reset under it.
        begin
            int guard = 0;
            while (!(mOut && mPend == MAXP) && guard < 200) begin
                @(negedge clk);
                step(1'b1, 1'b0);
                guard++;
            end
            vectors++;
            if (!(mOut && mPend == MAXP)) begin
                fails++;
                $display("FAIL reach_saturation: got busy=%b pending=%0d want busy=1 pending=%0d", mOut, mPend, MAXP);
            end
        end
        @(posedge clk);
        doReset("reset_mid_wait");

        // Single clean transfer after reset, then ordinary traffic.
        respMax = 3;
        @(negedge clk);
        step(1'b1, 1'b0);
        runPhase(30, 1000000, 0);
        runPhase(100, 6, 0);

        // Stray ack toggles while idle must raise the sticky protocol error.
        spurEn = 1'b1;
        runPhase(200, 10, 8);
        spurEn = 1'b0;
        runPhase(50, 6, 0);
        @(posedge clk);
        doReset("reset_clears_proto_err");

        runPhase(100, 4, 0);

        @(posedge clk);
        #2;
        vectors++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL queue_drained: got %0d entries left want 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/flag_handshake_tx.md
FLAG_HANDSHAKE_TX -- requirements
Module: flag_handshake_tx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on ack_toggle; legal range 2..4.
REQ-002 Parameter CNT_W, default 4, width of the pending-flag counter; legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk (external).
REQ-005 flag_in  input  1  single-cycle event flag in clk domain; each high cycle is one event.
REQ-006 ack_toggle  input  1  acknowledge level from remote domain, asynchronous to clk; each level change acknowledges one request.
REQ-007 overflow_clr  input  1  clears overflow when high for one cycle.
REQ-008 req_toggle  output  1  request level to remote domain; registered, changes level once per transmitted event.
REQ-009 busy  output  1  high while a request awaits acknowledge.
REQ-010 done  output  1  single-cycle pulse when an acknowledge completes a request.
REQ-011 pending  output  CNT_W  count of accepted events not yet transmitted.
REQ-012 overflow  output  1  sticky; an event was dropped because pending was saturated.
REQ-013 proto_err  output  1  sticky; ack_toggle changed while no request was outstanding.

Function
REQ-014 ack_toggle SHALL pass through SYNC_STAGES flops clocked by clk; ack_s is the last stage; no other logic SHALL sample ack_toggle.
REQ-015 FSM SHALL have two states: IDLE (busy=0) and WAIT_ACK (busy=1).
REQ-016 In IDLE, launch = flag_in OR (pending != 0); on launch, req_toggle SHALL invert and state SHALL become WAIT_ACK at the same edge.
REQ-017 Latency: flag_in high in cycle N with FSM in IDLE and pending=0 -> req_toggle inverted and busy=1 from cycle N+1.
REQ-018 In WAIT_ACK, when ack_s == req_toggle, state SHALL return to IDLE and done SHALL be 1 for exactly that next cycle.
REQ-019 A new launch SHALL NOT occur in the cycle done is high's originating edge; earliest relaunch is one cycle after return to IDLE.
REQ-020 pending update per edge: +1 if flag_in not consumed by launch; -1 if launch consumes a pending entry; simultaneous +1/-1 leaves it unchanged.
REQ-021 Launch with pending != 0 SHALL consume a pending entry (FIFO order irrelevant, events identical); launch with pending=0 consumes flag_in directly.
REQ-022 pending SHALL saturate at 2^CNT_W-1; an unconsumed flag_in at saturation SHALL leave pending unchanged and set overflow.
REQ-023 overflow_clr SHALL clear overflow; a simultaneous set condition SHALL win (overflow stays 1).
REQ-024 In IDLE, ack_s != req_toggle SHALL set proto_err (sticky until reset); FSM behaviour otherwise unaffected.
REQ-025 pending, overflow, proto_err, busy, done, req_toggle SHALL all be registered outputs.

Reset
REQ-026 On rst_n=0: state=IDLE, req_toggle=0, busy=0, done=0, pending=0, overflow=0, proto_err=0, all sync flops=0.
REQ-027 Reset mid-WAIT_ACK SHALL abandon the request and discard pending; remote side SHALL be reset concurrently (system requirement).
REQ-028 No launch SHALL occur in the first cycle after rst_n deasserts unless flag_in is high in that cycle.

Verification
REQ-029 Single flag: flag_in pulse at cycle 10, ack_toggle follows req_toggle 3 cycles later -> req_toggle 0->1 at 11, busy 11..(ack+SYNC_STAGES), one done pulse, pending stays 0.
REQ-030 Burst: 5 consecutive flag_in pulses, slow ack (20 cycles) -> pending peaks 4, exactly 5 req_toggle transitions and 5 done pulses, final pending=0.
REQ-031 Saturation (CNT_W=2): 6 flags during one outstanding request -> pending=3, overflow=1; overflow_clr -> overflow=0; total done pulses=4.
REQ-032 Simultaneous: flag_in high in the IDLE cycle with pending=2 -> launch occurs, pending remains 2.
REQ-033 Spurious ack: toggle ack_toggle while IDLE -> proto_err=1 after SYNC_STAGES+1 cycles, held until reset.
REQ-034 Reset during WAIT_ACK with pending=3 -> all outputs 0 immediately on rst_n low; clean single-flag transfer after release.
